// File: rtl/axis_power_spectrum.sv
// axis_power_spectrum: one-sided |X|^2 of a complex FFT stream, bins 0..N/2-1, tlast on bin N/2-1
module axis_power_spectrum #(
  parameter int AXIS_TDATA_WIDTH_IN  = 32,
  parameter int AXIS_TDATA_WIDTH_OUT = 32,
  parameter int LOG_FFT_LENGTH       = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            enable,
  input  logic [3:0]                      log_shift,
  input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic                            M_AXIS_tlast
);
  localparam logic [LOG_FFT_LENGTH-1:0] LAST_BIN = LOG_FFT_LENGTH'((1 << (LOG_FFT_LENGTH - 1)) - 1);
  logic [LOG_FFT_LENGTH-1:0] bin;
  logic ce, acc, v1, v2, l1, l2;
  logic signed [15:0] re1, im1;
  logic [31:0] p_re, p_im;
  assign ce = !M_AXIS_tvalid || M_AXIS_tready;
  assign S_AXIS_tready = aresetn && enable && ce;
  assign acc = S_AXIS_tvalid && S_AXIS_tready;
  // upper half of each frame is accepted but enters the pipeline as a bubble
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bin <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
      re1 <= '0;
      im1 <= '0;
      p_re <= '0;
      p_im <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast <= 1'b0;
      M_AXIS_tdata <= '0;
    end else begin
      bin <= !enable ? '0 : acc ? bin + 1'b1 : bin;
      if (ce) begin
        v1 <= acc && !bin[LOG_FFT_LENGTH-1];
        l1 <= bin == LAST_BIN;
        re1 <= S_AXIS_tdata[15:0];
        im1 <= S_AXIS_tdata[31:16];
        v2 <= v1;
        l2 <= l1;
        p_re <= 32'(re1) * 32'(re1);
        p_im <= 32'(im1) * 32'(im1);
        M_AXIS_tvalid <= v2;
        M_AXIS_tlast <= v2 && l2;
        M_AXIS_tdata <= AXIS_TDATA_WIDTH_OUT'((p_re + p_im) >> log_shift);
      end
    end
  end
endmodule

// File: tb/tb_axis_power_spectrum.sv
// tb_axis_power_spectrum: directed vectors with a bin-counting reference queue
module tb_axis_power_spectrum;
  logic aclk = 1'b0;
  logic aresetn, enable, s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic [3:0] log_shift;
  logic [31:0] s_tdata, m_tdata;
  logic rnd = 1'b0, trdy_fix = 1'b1, mon_en = 1'b0, hold = 1'b0, hl;
  logic [31:0] hd;
  logic [32:0] q[$];
  int total = 0, bad = 0, mbin = 0, nout = 0, cyc = 0, t0;

  axis_power_spectrum dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .log_shift(log_shift),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .M_AXIS_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;
  initial m_tready = 1'b1;
  always @(posedge aclk) begin
    #1 m_tready = rnd ? 1'($urandom_range(0, 1)) : trdy_fix;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // output monitor: order, value, tlast and hold-stability during stalls
  always @(negedge aclk) begin
    if (mon_en) begin
      if (m_tvalid && hold) begin
        chk("hold_data", m_tdata, hd);
        chk("hold_last", 32'(m_tlast), 32'(hl));
      end
      if (m_tvalid && m_tready) begin
        nout++;
        if (q.size() == 0) chk("extra_out", 32'(m_tvalid), 32'd0);
        else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("data", m_tdata, e[31:0]);
          chk("last", 32'(m_tlast), 32'(e[32]));
        end
      end
      hold = m_tvalid && !m_tready;
      hd = m_tdata;
      hl = m_tlast;
    end
  end

  task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
    int n = 0;
    longint p;
    s_tdata = {im, re};
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'(s_tready), 32'd1);
    else begin
      p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (mbin < 128) q.push_back({mbin == 127, 32'(p) >> log_shift});
      mbin = (mbin + 1) % 256;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    @(posedge aclk);
    #1;
    enable = 1'b1;
    mbin = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge aclk);
    repeat (6) @(posedge aclk);
    #1;
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    enable = 1'b1;
    log_shift = 4'd0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    mon_en = 1'b1;
    mbin = 0;
    // single beat latency
    send(16'sd3, 16'sd4);
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("lat_c1", 32'(m_tvalid), 32'd0);
    @(negedge aclk);
    chk("lat_c2", 32'(m_tvalid), 32'd0);
    @(negedge aclk);
    chk("lat_c3", 32'(m_tvalid), 32'd1);
    chk("lat_data", m_tdata, 32'd25);
    @(posedge aclk);
    #1;
    drain("drain_t1");
    // extreme magnitude and shifting
    send(-16'sd32768, -16'sd32768);
    s_tvalid = 1'b0;
    drain("drain_max");
    log_shift = 4'd4;
    send(16'sd20, 16'sd0);
    s_tvalid = 1'b0;
    drain("drain_shift");
    log_shift = 4'd0;
    // full frame, gapless
    restart();
    nout = 0;
    t0 = cyc;
    for (int i = 0; i < 256; i++) send(16'(i), 16'sd0);
    chk("gapless", 32'(cyc - t0), 32'd256);
    s_tvalid = 1'b0;
    drain("drain_frame");
    chk("frame_count", 32'(nout), 32'd128);
    // full frame under random backpressure
    restart();
    rnd = 1'b1;
    nout = 0;
    for (int i = 0; i < 256; i++) send(16'(i), 16'sd0);
    s_tvalid = 1'b0;
    drain("drain_bp");
    rnd = 1'b0;
    chk("bp_count", 32'(nout), 32'd128);
    // disable mid-frame, then re-enable at bin 0
    restart();
    for (int i = 0; i <= 50; i++) send(16'(i + 1), 16'sd2);
    enable = 1'b0;
    mbin = 0;
    s_tdata = 32'h0001_0001;
    @(negedge aclk);
    chk("dis_s_tready", 32'(s_tready), 32'd0);
    repeat (5) @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    drain("drain_dis");
    enable = 1'b1;
    nout = 0;
    for (int i = 0; i < 130; i++) send(16'(i * 3), -16'(i));
    s_tvalid = 1'b0;
    drain("drain_reen");
    chk("reen_count", 32'(nout), 32'd128);
    // reset mid-frame while output is held
    restart();
    mon_en = 1'b0;
    trdy_fix = 1'b0;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 3; i++) send(16'sd7, 16'sd1);
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
    chk("mid_rst_tdata", m_tdata, 32'd0);
    q.delete();
    mbin = 0;
    hold = 1'b0;
    trdy_fix = 1'b1;
    @(posedge aclk);
    #1;
    mon_en = 1'b1;
    nout = 0;
    for (int i = 0; i < 128; i++) send(16'(i + 5), 16'sd3);
    s_tvalid = 1'b0;
    drain("drain_rst");
    chk("rst_frame_count", 32'(nout), 32'd128);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
